// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall/forward scheduler for the 5-stage pipeline.
//
// Keeps a tag per in-flight stage (E, M, W) holding the destination
// register and remaining result latency (tnew), plus the mult/div busy
// counter. From that state and the D-stage operand requirements it
// derives, combinationally, the pipeline stall and the forwarding-mux
// select codes for the D, E and M stages.
//
// Ports:
//   clk                    pipeline clock, rising edge
//   reset                  asynchronous, active-low clear of all state
//   D_rs, D_rt             D-stage source registers
//   D_tuse_rs, D_tuse_rt   cycles until the operand is consumed (3 = unused)
//   D_wreg                 D-stage destination register (0 = no write)
//   D_tnew                 result latency on entry to E
//   D_md_start             00 none, 01 mult, 10 div
//   D_md_use               D instruction touches the mult/div unit or HI/LO
//   stall                  freeze PC and F/D, inject a bubble into E
//   D_fwd_rs, D_fwd_rt     1 = E PC+8, 2 = M result, 3 = W data, 0 = regfile
//   E_fwd_rs, E_fwd_rt     2 = M result, 3 = W data, 0 = pipeline value
//   M_fwd_rt               3 = W data, 0 = pipeline value
//   md_busy                mult/div unit occupied
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] D_wreg,
  input  logic [1:0] D_tnew,
  input  logic [1:0] D_md_start,
  input  logic       D_md_use,
  output logic       stall,
  output logic [3:0] D_fwd_rs,
  output logic [3:0] D_fwd_rt,
  output logic [1:0] E_fwd_rs,
  output logic [1:0] E_fwd_rt,
  output logic [1:0] M_fwd_rt,
  output logic       md_busy
);

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  // Only the tag fields somebody consumes are stored: M needs rt for the
  // M-stage forward, W needs only its destination (its tnew is always 0).
  logic [4:0] e_rs_q,   e_rs_d;
  logic [4:0] e_rt_q,   e_rt_d;
  logic [4:0] e_wreg_q, e_wreg_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [4:0] m_rt_q,   m_rt_d;
  logic [4:0] m_wreg_q, m_wreg_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic [4:0] w_wreg_q, w_wreg_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  // Operand hazard: an older writer whose result is not ready by the time
  // the D instruction consumes it. Register 0 never matches.
  function automatic logic data_hazard(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] e_wreg,
                                       input logic [1:0] e_tnew,
                                       input logic [4:0] m_wreg,
                                       input logic [1:0] m_tnew);
    logic hit;
    hit = 1'b0;
    if (src != 5'd0 && tuse != 2'd3) begin
      if (e_wreg == src && e_tnew > tuse) hit = 1'b1;
      if (m_wreg == src && m_tnew > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  // Newest writer wins. A not-yet-ready E or M writer selects the register
  // file rather than an older stage; the stale value is replaced by the
  // E/M forward once the result exists.
  function automatic logic [3:0] d_fwd_sel(input logic [4:0] src,
                                           input logic [4:0] e_wreg,
                                           input logic [1:0] e_tnew,
                                           input logic [4:0] m_wreg,
                                           input logic [1:0] m_tnew,
                                           input logic [4:0] w_wreg);
    logic [3:0] sel;
    sel = 4'd0;
    if (src != 5'd0) begin
      if (e_wreg == src)      sel = (e_tnew == 2'd0) ? 4'd1 : 4'd0;
      else if (m_wreg == src) sel = (m_tnew == 2'd0) ? 4'd2 : 4'd0;
      else if (w_wreg == src) sel = 4'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] e_fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_wreg,
                                           input logic [1:0] m_tnew,
                                           input logic [4:0] w_wreg);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0) begin
      if (m_wreg == src && m_tnew == 2'd0) sel = 2'd2;
      else if (w_wreg == src)              sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    md_busy  = (md_cnt_q != 4'd0);
    stall    = data_hazard(D_rs, D_tuse_rs, e_wreg_q, e_tnew_q, m_wreg_q, m_tnew_q)
             | data_hazard(D_rt, D_tuse_rt, e_wreg_q, e_tnew_q, m_wreg_q, m_tnew_q)
             | (D_md_use & md_busy);
    D_fwd_rs = d_fwd_sel(D_rs, e_wreg_q, e_tnew_q, m_wreg_q, m_tnew_q, w_wreg_q);
    D_fwd_rt = d_fwd_sel(D_rt, e_wreg_q, e_tnew_q, m_wreg_q, m_tnew_q, w_wreg_q);
    E_fwd_rs = e_fwd_sel(e_rs_q, m_wreg_q, m_tnew_q, w_wreg_q);
    E_fwd_rt = e_fwd_sel(e_rt_q, m_wreg_q, m_tnew_q, w_wreg_q);
    M_fwd_rt = (m_rt_q != 5'd0 && m_rt_q == w_wreg_q) ? 2'd3 : 2'd0;
  end

  always_comb begin
    w_wreg_d = m_wreg_q;
    m_rt_d   = e_rt_q;
    m_wreg_d = e_wreg_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    if (stall) begin
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
      e_wreg_d = 5'd0;
      e_tnew_d = 2'd0;
    end else begin
      e_rs_d   = D_rs;
      e_rt_d   = D_rt;
      e_wreg_d = D_wreg;
      e_tnew_d = D_tnew;
    end
    // A start always carries md_use, so it can only be accepted once the
    // counter has drained; a stalled cycle keeps counting down.
    if (!stall && D_md_start != 2'b00)
      md_cnt_d = D_md_start[1] ? DIV_LAT : MUL_LAT;
    else if (md_cnt_q != 4'd0)
      md_cnt_d = md_cnt_q - 4'd1;
    else
      md_cnt_d = md_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_wreg_q <= 5'd0;
      e_tnew_q <= 2'd0;
      m_rt_q   <= 5'd0;
      m_wreg_q <= 5'd0;
      m_tnew_q <= 2'd0;
      w_wreg_q <= 5'd0;
      md_cnt_q <= 4'd0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_wreg_q <= e_wreg_d;
      e_tnew_q <= e_tnew_d;
      m_rt_q   <= m_rt_d;
      m_wreg_q <= m_wreg_d;
      m_tnew_q <= m_tnew_d;
      w_wreg_q <= w_wreg_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_wreg;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew, D_md_start;
  logic       D_md_use;
  logic       stall, md_busy;
  logic [3:0] D_fwd_rs, D_fwd_rt;
  logic [1:0] E_fwd_rs, E_fwd_rt, M_fwd_rt;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_tuse_rs  (D_tuse_rs),
    .D_tuse_rt  (D_tuse_rt),
    .D_wreg     (D_wreg),
    .D_tnew     (D_tnew),
    .D_md_start (D_md_start),
    .D_md_use   (D_md_use),
    .stall      (stall),
    .D_fwd_rs   (D_fwd_rs),
    .D_fwd_rt   (D_fwd_rt),
    .E_fwd_rs   (E_fwd_rs),
    .E_fwd_rt   (E_fwd_rt),
    .M_fwd_rt   (M_fwd_rt),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one D-stage instruction.
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] wreg, input logic [1:0] tnew,
                       input logic [1:0] mds, input logic mdu);
    D_rs = rs; D_rt = rt; D_tuse_rs = tu_rs; D_tuse_rt = tu_rt;
    D_wreg = wreg; D_tnew = tnew; D_md_start = mds; D_md_use = mdu;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    // D reads $1 at Tuse 0 while in reset: empty tags mean no hazard.
    set_d(5'd1, 5'd2, 2'd0, 2'd0, 5'd3, 2'd1, 2'b00, 1'b1);
    #2;
    chk("rst_stall",    stall,    0);
    chk("rst_busy",     md_busy,  0);
    chk("rst_dfwd_rs",  D_fwd_rs, 0);
    chk("rst_efwd_rs",  E_fwd_rs, 0);
    chk("rst_mfwd_rt",  M_fwd_rt, 0);
    tick();
    reset = 1'b1;
    nop();
    tick();

    // lw $1 <- 0($2); addu $3, $1, $4
    set_d(5'd2, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'b00, 1'b0);
    #1 chk("lw_nostall", stall, 0);
    tick();
    set_d(5'd1, 5'd4, 2'd1, 2'd1, 5'd3, 2'd1, 2'b00, 1'b0);
    #1;
    chk("lw_use_stall",  stall,    1);
    chk("lw_use_dfwd",   D_fwd_rs, 0);
    tick();
    chk("lw_use_stall2", stall,    0);
    chk("lw_use_dfwd2",  D_fwd_rs, 0);
    tick();
    // addu now in E, bubble in M, lw in W.
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
    #1;
    chk("lw_efwd_rs",  E_fwd_rs, 3);
    chk("lw_efwd_rt",  E_fwd_rt, 0);
    chk("lw_dfwd_w",   D_fwd_rs, 3);
    chk("lw_stall3",   stall,    0);
    nop();
    tick();

    // Load followed by a branch (Tuse 0): two stall cycles.
    set_d(5'd2, 5'd0, 2'd1, 2'd3, 5'd6, 2'd2, 2'b00, 1'b0);
    tick();
    set_d(5'd6, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
    #1 chk("br_stall1", stall, 1);
    tick();
    chk("br_stall2", stall, 1);
    tick();
    chk("br_stall3", stall,    0);
    chk("br_dfwd",   D_fwd_rs, 3);
    nop();
    tick();
    tick();

    // jal in E, jr $31 in D
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'b00, 1'b0);
    tick();
    set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'b00, 1'b0);
    #1;
    chk("jr_stall", stall,    0);
    chk("jr_dfwd",  D_fwd_rs, 1);
    nop();
    tick();
    tick();
    tick();

    // addu $5,$6,$0 ; addu $5,$5,$5 ; D reads $5
    set_d(5'd6, 5'd0, 2'd1, 2'd1, 5'd5, 2'd1, 2'b00, 1'b0);
    tick();
    set_d(5'd5, 5'd5, 2'd1, 2'd1, 5'd5, 2'd1, 2'b00, 1'b0);
    #1 chk("a5_dfwd_e", D_fwd_rs, 0);
    tick();
    nop();
    #1;
    chk("a5_efwd_rs", E_fwd_rs, 2);
    chk("a5_efwd_rt", E_fwd_rt, 2);
    tick();
    set_d(5'd5, 5'd5, 2'd1, 2'd1, 5'd7, 2'd1, 2'b00, 1'b0);
    #1;
    chk("a5_stall",   stall,    0);
    chk("a5_dfwd_rs", D_fwd_rs, 2);
    chk("a5_dfwd_rt", D_fwd_rt, 2);
    chk("a5_mfwd_rt", M_fwd_rt, 3);
    nop();
    tick();
    tick();
    tick();

    // Writer of $0 with tnew 2 must not stall a reader of $0.
    set_d(5'd2, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 2'b00, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'b00, 1'b0);
    #1;
    chk("r0_stall", stall,    0);
    chk("r0_dfwd",  D_fwd_rs, 0);
    nop();
    tick();

    // mult then mflo: 5 stall cycles.
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd1, 2'b01, 1'b1);
    #1 chk("mul_pre_stall", stall, 0);
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mul_stall%0d", i), stall,   1);
      chk($sformatf("mul_busy%0d", i),  md_busy, 1);
      tick();
    end
    chk("mul_stall_end", stall,   0);
    chk("mul_busy_end",  md_busy, 0);
    nop();
    tick();

    // div then mflo: 10 stall cycles.
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd1, 2'b10, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 2'b00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("div_stall%0d", i), stall, 1);
      tick();
    end
    chk("div_stall_end", stall,   0);
    chk("div_busy_end",  md_busy, 0);
    nop();
    tick();

    // Asynchronous reset mid-stall with a load in E.
    set_d(5'd2, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 2'b00, 1'b0);
    tick();
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd3, 2'd1, 2'b00, 1'b0);
    #1 chk("rs_ld_stall", stall, 1);
    #1 reset = 1'b0;
    #1;
    chk("rs_ld_stall0", stall,    0);
    chk("rs_ld_dfwd",   D_fwd_rs, 0);
    #1 reset = 1'b1;
    #1 chk("rs_ld_stall1", stall, 0);
    nop();
    tick();

    // Asynchronous reset during a div with md_cnt = 7.
    set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd1, 2'b10, 1'b1);
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 2'b00, 1'b1);
    tick();
    tick();
    tick();
    chk("rs_div_busy", md_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rs_div_busy0",  md_busy, 0);
    chk("rs_div_stall0", stall,   0);
    #1 reset = 1'b1;
    nop();
    tick();
    chk("rs_div_busy1", md_busy, 0);
    tick();
    chk("rs_div_busy2", md_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
